serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial WIDTH-bit subtractor with a start/ready handshake.
//   Computes x - y - bin LSB-first, one bit per clock, using a single
//   full-subtractor cell and a registered borrow.
//   Complements the team's parallel adders: it uses less area in exchange
//   for multi-cycle latency, and serves as the subtract path in arithmetic
//   datapaths.
// PARAMETERS
//   WIDTH  8                 operand/result width; legal range >= 2
//   CNT_W  $clog2(WIDTH+1)   localparam; width of the bit counter
// PORTS
//   clk     in   1      single clock; all state updates on the rising edge
//   rst_n   in   1      asynchronous, active-low reset
//   start   in   1      request; accepted only when start && ready
//   x       in   WIDTH  minuend; sampled on the accept edge
//   y       in   WIDTH  subtrahend; sampled on the accept edge
//   bin     in   1      borrow-in; sampled on the accept edge
//   ready   out  1      high when state == IDLE (combinational from state)
//   diff    out  WIDTH  result register; updated only on completion
//   borrow  out  1      borrow-out register; updated only on completion
//   done    out  1      registered one-cycle pulse; result valid
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE; diff=0; borrow=0; done=0; ready=1.
//     - Internal shift registers, counter and borrow flop are cleared.
//   Reset mid-operation: the operation is aborted; no done pulse follows.
//   FSM states: IDLE, SHIFT, DONE.
//     IDLE : if start is high, capture x, y, bin into xs, ys, b;
//            clear cnt; go to SHIFT.
//     SHIFT: each edge:
//              d     = xs[0]^ys[0]^b
//              b     <= (~xs[0]&ys[0]) | (~(xs[0]^ys[0])&b)
//              ds    <= {d, ds[WIDTH-1:1]}
//              xs,ys shift right by 1
//              cnt   <= cnt+1
//            On the edge that processes bit WIDTH-1:
//              diff <= final ds; borrow <= final b; done <= 1;
//              go to DONE.
//     DONE : done <= 0; go to IDLE.
//   Timing (accept edge = E0):
//     - Bits are processed on E1..E_WIDTH.
//     - done=1 from E_WIDTH to E_WIDTH+1.
//     - ready returns to 1 after E_WIDTH+1.
//     - Throughput: one operation per WIDTH+2 cycles.
//   start while busy (SHIFT/DONE): ignored; not queued.
//     x/y/bin may change freely after E0.
//   diff/borrow never show partial results; they hold their value until
//     the next completion.
//   Arithmetic:
//     - diff   = (x - y - bin) mod 2^WIDTH
//     - borrow = 1 iff x < y + bin (unsigned)
// STRUCTURE
//   Package serial_subtractor_pkg:
//     - state typedef: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10
//     - ST_W=2 constant
//   Sub-module full_subtractor (combinational):
//     - inputs a, b, bi; outputs d, bo
//     - instantiated once for the per-bit cell.
//   Top level holds the FSM, counter, shift registers and output registers.
// TESTING (WIDTH=8)
//   1. Reset:
//      rst_n=0 mid-SHIFT -> immediately diff=0, borrow=0, done=0, ready=1;
//      no done pulse after release.
//   2. x=8'h5A, y=8'h23, bin=0 -> diff=8'h37, borrow=0;
//      done exactly 8 edges after the accept edge.
//   3. x=8'h00, y=8'h01, bin=0 -> diff=8'hFF, borrow=1 (wrap-around).
//   4. Borrow-in cases:
//      x=8'h10, y=8'h10, bin=1 -> diff=8'hFF, borrow=1;
//      x=8'h80, y=8'h7F, bin=1 -> diff=8'h00, borrow=0.
//   5. Hold start=1 with x/y toggling during SHIFT -> operands are ignored;
//      next accept occurs one cycle after done; back-to-back period is 10.
//   6. 1000 random x, y, bin vectors, checked against the model
//      {borrow,diff} = {1'b0,x} - {1'b0,y} - bin;
//      done is a single-cycle pulse every time.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state encoding for the bit-serial subtractor
//   ST_W    - width of the state register
//   state_t - IDLE (waiting for start), SHIFT (one bit per clock), DONE (result pulse)
package serial_subtractor_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit combinational subtractor cell computing a - b - bi
//   a  in  1  minuend bit
//   b  in  1  subtrahend bit
//   bi in  1  borrow-in
//   d  out 1  difference bit
//   bo out 1  borrow-out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial x - y - bin, LSB first, one bit per clock
//   clk    in  1      rising-edge clock
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      request, accepted when start && ready
//   x      in  WIDTH  minuend, sampled on accept
//   y      in  WIDTH  subtrahend, sampled on accept
//   bin    in  1      borrow-in, sampled on accept
//   ready  out 1      idle and able to accept
//   diff   out WIDTH  result, updated only on completion
//   borrow out 1      borrow-out, updated only on completion
//   done   out 1      one-cycle pulse when diff/borrow are fresh
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   xs_q, xs_d;
    logic [WIDTH-1:0]   ys_q, ys_d;
    logic [WIDTH-1:0]   ds_q, ds_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               b_q, b_d;
    logic               borrow_q, borrow_d;
    logic               done_q, done_d;
    logic               fs_d, fs_bo;
    logic               last_bit;

    full_subtractor u_fs (
        .a  (xs_q[0]),
        .b  (ys_q[0]),
        .bi (b_q),
        .d  (fs_d),
        .bo (fs_bo)
    );

    assign last_bit = cnt_q == CNT_W'(WIDTH - 1);

    always_comb begin
        state_d  = state_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        ds_d     = ds_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    b_d     = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ds_d  = {fs_d, ds_q[WIDTH-1:1]};
                b_d   = fs_bo;
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                // The final bit lands straight in the output register so the
                // visible result never carries a partially shifted value.
                if (last_bit) begin
                    diff_d   = ds_d;
                    borrow_d = fs_bo;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            xs_q     <= '0;
            ys_q     <= '0;
            ds_q     <= '0;
            b_q      <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            ds_q     <= ds_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign ready  = state_q == IDLE;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of the WIDTH=8 serial subtractor
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x = '0;
    logic [7:0] y = '0;
    logic       bin = 1'b0;
    logic       ready;
    logic [7:0] diff;
    logic       borrow;
    logic       done;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] hold_d = '0;
    logic       hold_b = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x      (x),
        .y      (y),
        .bin    (bin),
        .ready  (ready),
        .diff   (diff),
        .borrow (borrow),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Launches one operation and reports its latency (edges from accept to done),
    // whether outputs held their old value while busy, and whether done was a
    // single-cycle pulse followed by ready. Operands are scrambled after accept.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          output int lat, output logic held, output logic single);
        logic [8:0] m;
        int guard = 0;
        while (ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        x = a; y = b; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; x = ~a; y = 8'($urandom); bin = ~bi;
        lat = 0;
        held = 1'b1;
        while (done !== 1'b1 && lat < 20) begin
            if (diff !== hold_d || borrow !== hold_b) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        single = (done === 1'b0) && (ready === 1'b1);
        m = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        hold_d = m[7:0];
        hold_b = m[8];
    endtask

    task automatic test_reset();
        int lat;
        logic held, single, saw;
        #1;
        n_checks++; if (diff !== 8'h00)  begin n_fail++; $display("FAIL reset_diff got %h want 00", diff); end
        n_checks++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got %b want 0", borrow); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h5A, 8'h23, 1'b0, lat, held, single);
        n_checks++; if (diff !== 8'h37) begin n_fail++; $display("FAIL pre_abort_diff got %h want 37", diff); end
        x = 8'hFF; y = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (diff !== 8'h00)  begin n_fail++; $display("FAIL abort_diff got %h want 00", diff); end
        n_checks++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL abort_borrow got %b want 0", borrow); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        n_checks++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL abort_ready got %b want 1", ready); end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) saw = 1'b1;
        end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b want 0", saw); end
        hold_d = 8'h00;
        hold_b = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        logic held, single;
        run_op(8'h5A, 8'h23, 1'b0, lat, held, single);
        n_checks++; if (diff !== 8'h37)  begin n_fail++; $display("FAIL basic_diff got %h want 37", diff); end
        n_checks++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL basic_borrow got %b want 0", borrow); end
        n_checks++; if (lat !== 8)       begin n_fail++; $display("FAIL basic_latency got %0d want 8", lat); end
        n_checks++; if (held !== 1'b1)   begin n_fail++; $display("FAIL basic_hold got %b want 1", held); end
        n_checks++; if (single !== 1'b1) begin n_fail++; $display("FAIL basic_pulse got %b want 1", single); end
    endtask

    task automatic test_wrap();
        int lat;
        logic held, single;
        run_op(8'h00, 8'h01, 1'b0, lat, held, single);
        n_checks++; if (diff !== 8'hFF)  begin n_fail++; $display("FAIL wrap_diff got %h want ff", diff); end
        n_checks++; if (borrow !== 1'b1) begin n_fail++; $display("FAIL wrap_borrow got %b want 1", borrow); end
        n_checks++; if (held !== 1'b1)   begin n_fail++; $display("FAIL wrap_hold got %b want 1", held); end
    endtask

    task automatic test_borrow_in();
        int lat;
        logic held, single;
        run_op(8'h10, 8'h10, 1'b1, lat, held, single);
        n_checks++; if (diff !== 8'hFF)  begin n_fail++; $display("FAIL bin_eq_diff got %h want ff", diff); end
        n_checks++; if (borrow !== 1'b1) begin n_fail++; $display("FAIL bin_eq_borrow got %b want 1", borrow); end
        run_op(8'h80, 8'h7F, 1'b1, lat, held, single);
        n_checks++; if (diff !== 8'h00)  begin n_fail++; $display("FAIL bin_zero_diff got %h want 00", diff); end
        n_checks++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL bin_zero_borrow got %b want 0", borrow); end
        n_checks++; if (held !== 1'b1)   begin n_fail++; $display("FAIL bin_zero_hold got %b want 1", held); end
    endtask

    task automatic test_back_to_back();
        int lat, per, guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        x = 8'h5A; y = 8'h23; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            x = 8'($urandom); y = 8'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat !== 8)       begin n_fail++; $display("FAIL b2b_latency got %0d want 8", lat); end
        n_checks++; if (diff !== 8'h37)  begin n_fail++; $display("FAIL b2b_first_diff got %h want 37", diff); end
        n_checks++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL b2b_first_borrow got %b want 0", borrow); end
        x = 8'h80; y = 8'h7F; bin = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL b2b_ready got %b want 1", ready); end
        per = 1;
        while (done !== 1'b1 && per < 30) begin
            @(posedge clk); #1;
            per++;
        end
        start = 1'b0;
        n_checks++; if (per !== 10)      begin n_fail++; $display("FAIL b2b_period got %0d want 10", per); end
        n_checks++; if (diff !== 8'h00)  begin n_fail++; $display("FAIL b2b_second_diff got %h want 00", diff); end
        n_checks++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL b2b_second_borrow got %b want 0", borrow); end
        @(posedge clk); #1;
        hold_d = 8'h00;
        hold_b = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        logic held, single;
        logic [7:0] a, b;
        logic bi;
        logic [8:0] m;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
            m = {1'b0, a} - {1'b0, b} - {8'd0, bi};
            run_op(a, b, bi, lat, held, single);
            n_checks++;
            if ({borrow, diff} !== m || lat !== 8 || held !== 1'b1 || single !== 1'b1) begin
                n_fail++;
                $display("FAIL random_%0d x=%h y=%h bin=%b got b=%b d=%h lat=%0d held=%b pulse=%b want b=%b d=%h lat=8 held=1 pulse=1",
                         i, a, b, bi, borrow, diff, lat, held, single, m[8], m[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_borrow_in();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
